// File: rtl/stacker_row_trim.sv
// Stacker row shifter: a block of programmable length bounces across the row,
// and a stop press trims it to its overlap with the row below.
module stacker_row_trim #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned INIT_LEN = 3,
    parameter int unsigned STEP_DIV = 4
) (
    input  logic                         adjClkPulse,
    input  logic                         rst,
    input  logic                         startSw,
    input  logic                         stopBtn,
    input  logic                         speedUp,
    input  logic [WIDTH-1:0]             prev,
    input  logic [$clog2(WIDTH+1)-1:0]   loadLen,
    output logic [WIDTH-1:0]             newBlockLoc,
    output logic [$clog2(WIDTH+1)-1:0]   blockLen,
    output logic                         next,
    output logic                         miss,
    output logic                         done
);

    localparam int unsigned LW = $clog2(WIDTH + 1);
    localparam int unsigned PW = $clog2(WIDTH);
    localparam int unsigned DW = $clog2(STEP_DIV);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, RESULT} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic            dir_q, dir_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic [LW-1:0]   len_q, len_d;
    logic            stop_q, stop_d;
    logic [WIDTH-1:0] loc_q, loc_d;
    logic [LW-1:0]   blen_q, blen_d;
    logic            next_q, next_d;
    logic            miss_q, miss_d;
    logic            done_q, done_d;

    logic             press_c;
    logic [LW-1:0]    eff_len_c;
    logic [PW-1:0]    lim_c;
    logic [DW-1:0]    thr_c;
    logic [WIDTH-1:0] ov_c;

    function automatic logic [WIDTH-1:0] place(logic [PW-1:0] p, logic [LW-1:0] l);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < int'(WIDTH); i++) begin
            r[i] = (i >= int'(p)) && (i < int'(p) + int'(l));
        end
        return r;
    endfunction

    function automatic logic [LW-1:0] popcount(logic [WIDTH-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (v[i]) cnt++;
        end
        return LW'(cnt);
    endfunction

    // Effective row length: zero picks the default, oversize clamps to the row.
    always_comb begin
        if (loadLen == '0) begin
            eff_len_c = LW'(INIT_LEN);
        end else if (int'(loadLen) > int'(WIDTH)) begin
            eff_len_c = LW'(WIDTH);
        end else begin
            eff_len_c = loadLen;
        end
    end

    assign press_c = stop_q & ~stopBtn;
    assign lim_c   = PW'(int'(WIDTH) - int'(len_q));
    assign thr_c   = speedUp ? DW'(STEP_DIV / 2 - 1) : DW'(STEP_DIV - 1);
    assign ov_c    = (prev == '0) ? loc_q : (loc_q & prev);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        dir_d   = dir_q;
        pos_d   = pos_q;
        len_d   = len_q;
        stop_d  = stopBtn;
        loc_d   = loc_q;
        blen_d  = blen_q;
        next_d  = next_q;
        miss_d  = miss_q;
        done_d  = 1'b0;

        if (!startSw) begin
            state_d = IDLE;
            loc_d   = '1;
            blen_d  = '0;
            next_d  = 1'b0;
            miss_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = LOAD;
                    loc_d   = '1;
                end
                LOAD: begin
                    len_d   = eff_len_c;
                    pos_d   = PW'(int'(WIDTH) - int'(eff_len_c));
                    dir_d   = 1'b0;
                    div_d   = '0;
                    loc_d   = place(PW'(int'(WIDTH) - int'(eff_len_c)), eff_len_c);
                    state_d = SHIFT;
                end
                SHIFT: begin
                    // A press wins over a coinciding step and freezes the current pattern.
                    if (press_c) begin
                        state_d = RESULT;
                        done_d  = 1'b1;
                        if (ov_c != '0) begin
                            loc_d  = ov_c;
                            blen_d = popcount(ov_c);
                            next_d = 1'b1;
                            miss_d = 1'b0;
                        end else begin
                            loc_d  = '0;
                            blen_d = '0;
                            next_d = 1'b0;
                            miss_d = 1'b1;
                        end
                    end else if (div_q == thr_c) begin
                        div_d = '0;
                        if (len_q != LW'(WIDTH)) begin
                            if (!dir_q) begin
                                if (pos_q == '0) begin
                                    dir_d = 1'b1;
                                    pos_d = PW'(1);
                                end else begin
                                    pos_d = pos_q - PW'(1);
                                end
                            end else begin
                                if (pos_q == lim_c) begin
                                    dir_d = 1'b0;
                                    pos_d = pos_q - PW'(1);
                                end else begin
                                    pos_d = pos_q + PW'(1);
                                end
                            end
                            loc_d = place(pos_d, len_q);
                        end
                    end else begin
                        div_d = div_q + DW'(1);
                    end
                end
                RESULT: begin
                    state_d = RESULT;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge adjClkPulse) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            dir_q   <= 1'b0;
            pos_q   <= '0;
            len_q   <= '0;
            stop_q  <= 1'b0;
            loc_q   <= '0;
            blen_q  <= '0;
            next_q  <= 1'b0;
            miss_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
            len_q   <= len_d;
            stop_q  <= stop_d;
            loc_q   <= loc_d;
            blen_q  <= blen_d;
            next_q  <= next_d;
            miss_q  <= miss_d;
            done_q  <= done_d;
        end
    end

    assign newBlockLoc = loc_q;
    assign blockLen    = blen_q;
    assign next        = next_q;
    assign miss        = miss_q;
    assign done        = done_q;

endmodule

// File: tb/tb_stacker_row_trim.sv
// Directed bench for stacker_row_trim: one instance at STEP_DIV=2, one at STEP_DIV=4.
module tb_stacker_row_trim;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LW    = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst;
    logic             startSw;
    logic             stopBtn;
    logic             speedUp;
    logic [WIDTH-1:0] prev;
    logic [LW-1:0]    loadLen;

    logic [WIDTH-1:0] loc2, loc4;
    logic [LW-1:0]    blen2, blen4;
    logic             next2, next4, miss2, miss4, done2, done4;

    int n_checks;
    int n_fail;

    stacker_row_trim #(.WIDTH(WIDTH), .INIT_LEN(3), .STEP_DIV(2)) u_dut2 (
        .adjClkPulse(clk), .rst(rst), .startSw(startSw), .stopBtn(stopBtn),
        .speedUp(speedUp), .prev(prev), .loadLen(loadLen),
        .newBlockLoc(loc2), .blockLen(blen2), .next(next2), .miss(miss2), .done(done2)
    );

    stacker_row_trim #(.WIDTH(WIDTH), .INIT_LEN(3), .STEP_DIV(4)) u_dut4 (
        .adjClkPulse(clk), .rst(rst), .startSw(startSw), .stopBtn(stopBtn),
        .speedUp(speedUp), .prev(prev), .loadLen(loadLen),
        .newBlockLoc(loc4), .blockLen(blen4), .next(next4), .miss(miss4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [WIDTH-1:0] bounce [12];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bounce = '{8'hE0, 8'h70, 8'h38, 8'h1C, 8'h0E, 8'h07,
                   8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h70};

        rst = 1'b1; startSw = 1'b0; stopBtn = 1'b1; speedUp = 1'b0;
        prev = '0; loadLen = '0;
        tick(2);
        check("rst_loc", 32'(loc2), 32'h00);
        check("rst_blen", 32'(blen2), 32'h0);
        check("rst_next", 32'(next2), 32'h0);
        check("rst_miss", 32'(miss2), 32'h0);
        check("rst_done", 32'(done2), 32'h0);
        rst = 1'b0;
        tick(1);
        check("idle_loc", 32'(loc2), 32'hFF);

        // Free-running bounce, two cycles per pattern.
        startSw = 1'b1;
        tick(1);
        check("load_loc", 32'(loc2), 32'hFF);
        tick(1);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("bounce%0d_a", i), 32'(loc2), 32'(bounce[i]));
            tick(1);
            check($sformatf("bounce%0d_b", i), 32'(loc2), 32'(bounce[i]));
            tick(1);
        end
        check("bounce_next", 32'(next2), 32'h0);
        check("bounce_done", 32'(done2), 32'h0);

        // First row: no trim.
        check("row1_prepress", 32'(loc2), 32'h38);
        stopBtn = 1'b0;
        tick(1);
        check("row1_loc", 32'(loc2), 32'h38);
        check("row1_blen", 32'(blen2), 32'h3);
        check("row1_next", 32'(next2), 32'h1);
        check("row1_miss", 32'(miss2), 32'h0);
        check("row1_done", 32'(done2), 32'h1);
        tick(1);
        check("row1_done_pulse", 32'(done2), 32'h0);
        check("row1_hold", 32'(loc2), 32'h38);

        // Partial trim, then holding the button and changing prev must not matter.
        stopBtn = 1'b1; startSw = 1'b0;
        tick(1);
        check("abort_loc", 32'(loc2), 32'hFF);
        prev = 8'h38; loadLen = LW'(3); startSw = 1'b1;
        tick(2);
        check("row2_start", 32'(loc2), 32'hE0);
        tick(6);
        check("row2_prepress", 32'(loc2), 32'h1C);
        stopBtn = 1'b0;
        tick(1);
        check("row2_loc", 32'(loc2), 32'h18);
        check("row2_blen", 32'(blen2), 32'h2);
        check("row2_next", 32'(next2), 32'h1);
        check("row2_miss", 32'(miss2), 32'h0);
        check("row2_done", 32'(done2), 32'h1);
        prev = 8'h00;
        tick(20);
        check("row2_hold_loc", 32'(loc2), 32'h18);
        check("row2_hold_blen", 32'(blen2), 32'h2);
        check("row2_hold_done", 32'(done2), 32'h0);

        // Miss: zero overlap.
        stopBtn = 1'b1; startSw = 1'b0;
        tick(1);
        prev = 8'h03; loadLen = LW'(2); startSw = 1'b1;
        tick(2);
        check("row3_prepress", 32'(loc2), 32'hC0);
        stopBtn = 1'b0;
        tick(1);
        check("row3_loc", 32'(loc2), 32'h00);
        check("row3_blen", 32'(blen2), 32'h0);
        check("row3_miss", 32'(miss2), 32'h1);
        check("row3_next", 32'(next2), 32'h0);
        check("row3_done", 32'(done2), 32'h1);

        // Oversize length clamps to a full, stationary row.
        stopBtn = 1'b1; startSw = 1'b0;
        tick(1);
        check("row3_abort_miss", 32'(miss2), 32'h0);
        prev = 8'h00; loadLen = LW'(12); startSw = 1'b1;
        tick(8);
        check("clamp_loc", 32'(loc2), 32'hFF);
        stopBtn = 1'b0;
        tick(1);
        check("clamp_blen", 32'(blen2), 32'h8);
        check("clamp_next", 32'(next2), 32'h1);

        // Speed-up on the STEP_DIV=4 instance, then normal speed.
        stopBtn = 1'b1; startSw = 1'b0;
        tick(1);
        loadLen = '0; speedUp = 1'b1; startSw = 1'b1;
        tick(2);
        check("fast_e0_a", 32'(loc4), 32'hE0);
        tick(1);
        check("fast_e0_b", 32'(loc4), 32'hE0);
        tick(1);
        check("fast_70", 32'(loc4), 32'h70);
        tick(2);
        check("fast_38", 32'(loc4), 32'h38);
        speedUp = 1'b0;
        tick(3);
        check("slow_38_hold", 32'(loc4), 32'h38);
        tick(1);
        check("slow_1c", 32'(loc4), 32'h1C);

        // Abort and reset in the middle of shifting.
        startSw = 1'b0;
        tick(1);
        check("mid_abort4", 32'(loc4), 32'hFF);
        check("mid_abort2", 32'(loc2), 32'hFF);
        startSw = 1'b1;
        tick(5);
        rst = 1'b1;
        tick(1);
        check("mid_rst_loc", 32'(loc4), 32'h00);
        check("mid_rst_done", 32'(done4), 32'h0);
        rst = 1'b0; startSw = 1'b0;
        tick(1);
        check("post_rst_idle", 32'(loc4), 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stacker_row_trim.md
Name: stacker_row_trim

Overview:
- Next-generation row shifter for the stacker game; generalises the fixed 8-bit single-lit row shifter.
- A multi-cell block of parametrised width bounces across a WIDTH-cell row at a programmable step rate.
- When the player stops it, the block is trimmed to its overlap with the row below.
- It reports the surviving pattern, the new length, and hit/miss. It sits between the button/switch inputs and the row-display register stack.

Parameters:
- WIDTH, 8: number of cells in a row; must be >= 2.
- INIT_LEN, 3: initial block length in cells; 1 <= INIT_LEN <= WIDTH.
- STEP_DIV, 4: clock cycles per shift step in normal speed; must be even and >= 2.

Ports:
- adjClkPulse, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- startSw, input, 1: game enable; low forces IDLE.
- stopBtn, input, 1: stop request, active-low (0 = pressed).
- speedUp, input, 1: 1 = step every STEP_DIV/2 cycles; sampled at each step decision.
- prev, input, WIDTH: pattern of the row below; all-zero means first row (no trim).
- loadLen, input, $clog2(WIDTH+1): block length for this row; 0 selects INIT_LEN; values > WIDTH are clamped to WIDTH.
- newBlockLoc, output, WIDTH: current or latched row pattern.
- blockLen, output, $clog2(WIDTH+1): popcount of the latched result.
- next, output, 1: 1 = stop landed on or inside prev, so the game may advance.
- miss, output, 1: 1 = zero overlap; game over.
- done, output, 1: single-cycle pulse when the result becomes valid.

Behaviour:
- Reset (rst=1 at an edge, overriding everything):
  - state=IDLE, newBlockLoc=0, blockLen=0, next=0, miss=0, done=0.
  - divider=0, dir=0, pos=0, stop synchroniser cleared.
- States: IDLE, LOAD, SHIFT, RESULT.
- IDLE:
  - startSw=0: newBlockLoc = all ones, next=miss=done=0.
  - startSw=1: go to LOAD next cycle.
  - startSw=0 in any state: return to IDLE on the next edge and drive newBlockLoc all ones. This abandons the row.
- LOAD (one cycle):
  - L = effective loadLen.
  - pos = WIDTH-L, so the block is left-aligned at the MSB.
  - dir=0, divider=0, newBlockLoc = L ones at bits [pos+L-1:pos].
  - Go to SHIFT.
- SHIFT:
  - Divider threshold T = STEP_DIV-1, or STEP_DIV/2-1 when speedUp=1.
  - When divider==T: divider<=0 and one step occurs. Otherwise divider increments.
  - Step, dir=0 (moving right):
    - pos==0: dir<=1, pos<=1.
    - otherwise pos<=pos-1.
  - Step, dir=1 (moving left):
    - pos==WIDTH-L: dir<=0, pos<=pos-1.
    - otherwise pos<=pos+1.
  - The block never dwells at an edge for two steps.
  - If L==WIDTH, pos stays 0 and no movement occurs.
  - newBlockLoc updates the same edge pos updates.
- Stop detect:
  - stopBtn is registered once; a press is the registered value going 1->0 (falling edge).
  - A press while not in SHIFT is ignored.
  - Holding the button does not re-trigger.
  - A press on the same edge as a step: the step is suppressed and the current pattern is used.
- Trim (on the press edge): ov = prev==0 ? newBlockLoc : (newBlockLoc & prev).
  - ov != 0: newBlockLoc<=ov, blockLen<=popcount(ov), next<=1, miss<=0.
  - ov == 0: newBlockLoc<=0, blockLen<=0, next<=0, miss<=1.
  - done<=1 for exactly one cycle. Go to RESULT.
- RESULT:
  - All outputs hold; ignore stopBtn and prev changes.
  - startSw falling returns to IDLE.
  - A new row requires startSw to cycle low then high.
- Widths: pos is $clog2(WIDTH) bits. blockLen is computed combinationally from ov and registered.

Test Plan:
- Reset: WIDTH=8, INIT_LEN=3, STEP_DIV=2, rst=1 for 2 cycles -> newBlockLoc=0x00, next=miss=done=0. Release with startSw=0 -> newBlockLoc=0xFF.
- Bounce: startSw=1, loadLen=0, speedUp=0, no press -> pattern sequence E0, 70, 38, 1C, 0E, 07, 0E, 1C, ..., E0, 70, one change every 2 cycles.
- First row: prev=0x00, press when pattern=0x38 -> newBlockLoc=0x38, blockLen=3, next=1, miss=0, done high exactly 1 cycle.
- Partial trim: prev=0x38, loadLen=3, press at 0x1C -> newBlockLoc=0x18, blockLen=2, next=1. Holding stopBtn low 20 cycles changes nothing.
- Miss: prev=0x03, loadLen=2, press at 0xC0 -> newBlockLoc=0x00, blockLen=0, miss=1, next=0.
- Speed/abort: speedUp=1, STEP_DIV=4 -> step every 2 cycles. Drop startSw mid-SHIFT -> 0xFF next edge. Assert rst mid-SHIFT -> 0x00 next edge.
